// File: rtl/memory_access_stage_pkg.sv
// Shared processor encodings for the Memory stage: access width, result select,
// and the Memory pipeline register layout.
package memory_access_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        WIDTH_WORD  = 3'b000,
        WIDTH_HALF  = 3'b001,
        WIDTH_BYTE  = 3'b010,
        WIDTH_HALFU = 3'b011,
        WIDTH_BYTEU = 3'b100
    } width_e;

    typedef enum logic [2:0] {
        RES_ALU = 3'b000,
        RES_MEM = 3'b001,
        RES_PC4 = 3'b010,
        RES_IMM = 3'b011,
        RES_PCT = 3'b100
    } result_e;

    typedef struct packed {
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       write_data;
        logic [XLEN-1:0]       pc_target;
        logic [XLEN-1:0]       pc_plus4;
        logic [XLEN-1:0]       imm_ext;
        logic [REG_ADDR_W-1:0] rd;
        width_e                width_src;
        result_e               result_src;
        logic                  valid;
        logic                  reg_write;
        logic                  mem_write;
    } mem_stage_t;

    function automatic logic is_half(input width_e w);
        return (w == WIDTH_HALF) || (w == WIDTH_HALFU);
    endfunction

    function automatic logic is_byte(input width_e w);
        return (w == WIDTH_BYTE) || (w == WIDTH_BYTEU);
    endfunction

    function automatic logic is_misaligned(input width_e w, input logic [1:0] offset);
        if (w == WIDTH_WORD) begin
            return offset != 2'b00;
        end
        return is_half(w) && offset[0];
    endfunction

endpackage

// File: rtl/memory_access_stage_load_extend.sv
// Load lane selection and sign/zero extension of raw memory read data.
module load_extend
    import memory_access_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  width_e          width_src,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (width_src)
            WIDTH_HALF:  data = {{16{half_lane[15]}}, half_lane};
            WIDTH_HALFU: data = {16'h0000, half_lane};
            WIDTH_BYTE:  data = {{24{byte_lane[7]}}, byte_lane};
            WIDTH_BYTEU: data = {24'h000000, byte_lane};
            default:     data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Memory pipeline stage: Memory pipeline register, data-memory request FSM with
// grant/rvalid handshake, store lane steering, load buffer and result forwarding.
module memory_access_stage
    import memory_access_stage_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [XLEN-1:0]       alu_result_e_i,
    input  logic [XLEN-1:0]       write_data_e_i,
    input  logic [XLEN-1:0]       pc_target_e_i,
    input  logic [XLEN-1:0]       pc_plus4_e_i,
    input  logic [XLEN-1:0]       imm_ext_e_i,
    input  logic [REG_ADDR_W-1:0] rd_e_i,
    input  logic [2:0]            width_src_e_i,
    input  logic [2:0]            result_src_e_i,
    input  logic                  valid_e_i,
    input  logic                  reg_write_e_i,
    input  logic                  mem_write_e_i,
    input  logic                  stall_m_i,
    input  logic                  flush_m_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [XLEN-1:0]       dmem_addr_o,
    output logic [XLEN-1:0]       dmem_wdata_o,
    output logic [3:0]            dmem_be_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,
    output logic [XLEN-1:0]       alu_result_m_o,
    output logic [XLEN-1:0]       read_data_m_o,
    output logic [XLEN-1:0]       forward_data_m_o,
    output logic [XLEN-1:0]       pc_target_m_o,
    output logic [XLEN-1:0]       pc_plus4_m_o,
    output logic [XLEN-1:0]       imm_ext_m_o,
    output logic [REG_ADDR_W-1:0] rd_m_o,
    output logic [2:0]            result_src_m_o,
    output logic                  valid_m_o,
    output logic                  reg_write_m_o,
    output logic                  mem_busy_o,
    output logic                  misalign_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RSP,
        DONE
    } state_e;

    state_e          state;
    state_e          state_next;
    mem_stage_t      e_in;
    mem_stage_t      m;
    logic            discard;
    logic            discard_next;
    logic            load_buf_en;
    logic [XLEN-1:0] load_buf;
    logic [XLEN-1:0] load_data;
    logic            is_store;
    logic            is_load;
    logic            mem_op;
    logic            misaligned;
    logic            pending;

    always_comb begin
        e_in            = '0;
        e_in.alu_result = alu_result_e_i;
        e_in.write_data = write_data_e_i;
        e_in.pc_target  = pc_target_e_i;
        e_in.pc_plus4   = pc_plus4_e_i;
        e_in.imm_ext    = imm_ext_e_i;
        e_in.rd         = rd_e_i;
        e_in.width_src  = width_e'(width_src_e_i);
        e_in.result_src = result_e'(result_src_e_i);
        e_in.valid      = valid_e_i;
        e_in.reg_write  = reg_write_e_i;
        e_in.mem_write  = mem_write_e_i;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            m <= '0;
        end else if (flush_m_i) begin
            m <= '0;
        end else if (!stall_m_i) begin
            m <= e_in;
        end
    end

    assign is_store   = m.valid && m.mem_write;
    assign is_load    = m.valid && !m.mem_write && (m.result_src == RES_MEM);
    assign mem_op     = is_store || is_load;
    assign misaligned = is_misaligned(m.width_src, m.alu_result[1:0]);
    // Only IDLE can owe a request; WAIT_RSP/DONE mean this access is already granted.
    assign pending    = mem_op && !misaligned && (state == IDLE);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state   <= IDLE;
            discard <= 1'b0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
        end
    end

    always_comb begin
        state_next   = state;
        discard_next = discard;
        load_buf_en  = 1'b0;
        dmem_req_o   = 1'b0;
        mem_busy_o   = 1'b0;
        case (state)
            IDLE: begin
                dmem_req_o = pending;
                mem_busy_o = pending && !(dmem_gnt_i && is_store);
                if (pending && dmem_gnt_i) begin
                    if (is_store) begin
                        if (stall_m_i && !flush_m_i) begin
                            state_next = DONE;
                        end
                    end else begin
                        state_next   = WAIT_RSP;
                        discard_next = flush_m_i;
                    end
                end
            end
            WAIT_RSP: begin
                // A flushed load still owns the bus until its response drains.
                mem_busy_o = 1'b1;
                if (flush_m_i) begin
                    discard_next = 1'b1;
                end
                if (dmem_rvalid_i) begin
                    if (discard || flush_m_i) begin
                        state_next   = IDLE;
                        discard_next = 1'b0;
                    end else begin
                        load_buf_en = 1'b1;
                        state_next  = DONE;
                    end
                end
            end
            DONE: begin
                if (!stall_m_i || flush_m_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                discard_next = 1'b0;
            end
        endcase
    end

    load_extend u_load_extend (
        .rdata     (dmem_rdata_i),
        .offset    (m.alu_result[1:0]),
        .width_src (m.width_src),
        .data      (load_data)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            load_buf <= '0;
        end else if (load_buf_en) begin
            load_buf <= load_data;
        end
    end

    always_comb begin
        dmem_be_o    = '0;
        dmem_wdata_o = m.write_data;
        if (is_store) begin
            if (is_byte(m.width_src)) begin
                dmem_be_o    = 4'b0001 << m.alu_result[1:0];
                dmem_wdata_o = {4{m.write_data[7:0]}};
            end else if (is_half(m.width_src)) begin
                dmem_be_o    = m.alu_result[1] ? 4'b1100 : 4'b0011;
                dmem_wdata_o = {2{m.write_data[15:0]}};
            end else begin
                dmem_be_o    = '1;
            end
        end
    end

    assign dmem_we_o   = dmem_req_o && m.mem_write;
    assign dmem_addr_o = {m.alu_result[XLEN-1:2], 2'b00};

    always_comb begin
        forward_data_m_o = m.alu_result;
        case (m.result_src)
            RES_PC4: forward_data_m_o = m.pc_plus4;
            RES_IMM: forward_data_m_o = m.imm_ext;
            RES_PCT: forward_data_m_o = m.pc_target;
            default: forward_data_m_o = m.alu_result;
        endcase
    end

    assign alu_result_m_o = m.alu_result;
    assign read_data_m_o  = load_buf;
    assign pc_target_m_o  = m.pc_target;
    assign pc_plus4_m_o   = m.pc_plus4;
    assign imm_ext_m_o    = m.imm_ext;
    assign rd_m_o         = m.rd;
    assign result_src_m_o = m.result_src;
    assign valid_m_o      = m.valid;
    assign reg_write_m_o  = m.reg_write && m.valid;
    assign misalign_o     = mem_op && misaligned;

endmodule
